// File: rtl/image_bias_pkg.sv
// ----------------------------------------------------------------------------
// image_bias_pkg
// Shared constants and FSM encoding for the image bias controller.
//   BIAS_FIFO_DEPTH    : entries in the external bias FIFO
//   BIAS_FIFO_S_MARGIN : write-space threshold handed to the FIFO
//   bias_state_t       : read-side FSM state encoding
// ----------------------------------------------------------------------------
package image_bias_pkg;

    localparam int unsigned BIAS_FIFO_DEPTH = 4096;

    // The FIFO's S_Ready flag is registered, so it can lag by one write.
    // Asking for two free slots covers the write that lands while it is stale.
    localparam int unsigned BIAS_FIFO_S_MARGIN = 2;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CHECK   = 3'd1,
        ST_WAIT    = 3'd2,
        ST_POP     = 3'd3,
        ST_LOAD    = 3'd4,
        ST_PRESENT = 3'd5,
        ST_DONE    = 3'd6
    } bias_state_t;

endpackage

// File: rtl/image_bias_ctrl_if.sv
// ----------------------------------------------------------------------------
// image_bias_ctrl_if
// Bundles the three handshakes around the bias controller:
//   s_*     : upstream (DMA) bias word stream into the controller
//   fifo_*  : external bias FIFO write/read ports and threshold flags
//   bias_*  : bias word presented to the compute engine
// master = controller side, slave = environment side (DMA, FIFO, engine).
// ----------------------------------------------------------------------------
interface image_bias_ctrl_if #(
    parameter int WIDTH     = 256,
    parameter int ADDR_BITS = 12
);
    logic                 s_valid;
    logic [WIDTH-1:0]     s_data;
    logic                 s_ready;

    logic [WIDTH-1:0]     fifo_din;
    logic                 fifo_wr_en;
    logic                 fifo_rd_en;
    logic [WIDTH-1:0]     fifo_dout;
    logic [ADDR_BITS:0]   fifo_M_count;
    logic                 fifo_M_Valid;
    logic [ADDR_BITS:0]   fifo_S_count;
    logic                 fifo_S_Ready;

    logic [WIDTH-1:0]     bias_data;
    logic                 bias_valid;
    logic                 bias_ready;

    modport master (
        input  s_valid, s_data, fifo_dout, fifo_M_Valid, fifo_S_Ready, bias_ready,
        output s_ready, fifo_din, fifo_wr_en, fifo_rd_en, fifo_M_count, fifo_S_count,
               bias_data, bias_valid
    );

    modport slave (
        output s_valid, s_data, fifo_dout, fifo_M_Valid, fifo_S_Ready, bias_ready,
        input  s_ready, fifo_din, fifo_wr_en, fifo_rd_en, fifo_M_count, fifo_S_count,
               bias_data, bias_valid
    );
endinterface

// File: rtl/image_bias_ctrl.sv
// ----------------------------------------------------------------------------
// image_bias_ctrl
// Streams a layer's bias words from the DMA into an external FIFO and, once
// the whole layer is resident, pops them one at a time to the compute engine.
//   clk, rst (async, active-low)
//   start / ch_groups : begin a layer of ch_groups bias words
//   busy / done / err : status; err is sticky until the next start
//   bus (master)      : DMA stream, FIFO ports, engine bias handshake
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | waiting for start
// CHECK    | validate the latched word count
// WAIT     | M_count = layer size; wait for the whole layer in the FIFO
// POP      | one-cycle FIFO read strobe
// LOAD     | capture FIFO read data into the output register
// PRESENT  | hold bias word until the engine accepts it
// DONE     | one-cycle done pulse
// ----------------------------------------------------------------------------
module image_bias_ctrl
    import image_bias_pkg::*;
#(
    parameter int WIDTH     = 256,
    parameter int ADDR_BITS = 12
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [ADDR_BITS:0]  ch_groups,
    output logic                busy,
    output logic                done,
    output logic                err,
    image_bias_ctrl_if.master   bus
);
    localparam logic [ADDR_BITS:0] C_DEPTH    = (ADDR_BITS+1)'(BIAS_FIFO_DEPTH);
    localparam logic [ADDR_BITS:0] C_S_MARGIN = (ADDR_BITS+1)'(BIAS_FIFO_S_MARGIN);
    localparam logic [ADDR_BITS:0] C_ONE      = (ADDR_BITS+1)'(1);

    bias_state_t         r_state;
    bias_state_t         w_next;
    logic [ADDR_BITS:0]  r_grp;
    logic [ADDR_BITS:0]  r_cnt;
    logic                r_err;
    logic                r_wait_armed;
    logic                r_bias_valid;
    logic [WIDTH-1:0]    r_bias_data;
    logic                w_last;

    // Write path runs in every state, independent of the read FSM.
    assign bus.fifo_din     = bus.s_data;
    assign bus.fifo_wr_en   = bus.s_valid & bus.fifo_S_Ready;
    assign bus.s_ready      = bus.fifo_S_Ready;
    assign bus.fifo_S_count = C_S_MARGIN;

    assign bus.bias_data  = r_bias_data;
    assign bus.bias_valid = r_bias_valid;
    assign err            = r_err;

    assign w_last = (r_cnt == r_grp - C_ONE);

    always_comb begin
        w_next           = r_state;
        busy             = (r_state != ST_IDLE);
        done             = 1'b0;
        bus.fifo_rd_en   = 1'b0;
        bus.fifo_M_count = '0;
        case (r_state)
            ST_IDLE: begin
                if (start) w_next = ST_CHECK;
            end
            ST_CHECK: begin
                if (r_grp == '0 || r_grp > C_DEPTH) w_next = ST_DONE;
                else                                w_next = ST_WAIT;
            end
            ST_WAIT: begin
                bus.fifo_M_count = r_grp;
                // M_Valid is registered against the previous M_count on the
                // first WAIT cycle, so only trust it from the second cycle on.
                if (r_wait_armed && bus.fifo_M_Valid) w_next = ST_POP;
            end
            ST_POP: begin
                bus.fifo_rd_en = 1'b1;
                w_next         = ST_LOAD;
            end
            ST_LOAD: begin
                w_next = ST_PRESENT;
            end
            ST_PRESENT: begin
                if (bus.bias_ready) w_next = w_last ? ST_DONE : ST_POP;
            end
            ST_DONE: begin
                done   = 1'b1;
                w_next = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= ST_IDLE;
            r_grp        <= '0;
            r_cnt        <= '0;
            r_err        <= 1'b0;
            r_wait_armed <= 1'b0;
            r_bias_valid <= 1'b0;
            r_bias_data  <= '0;
        end else begin
            r_state      <= w_next;
            r_wait_armed <= (r_state == ST_WAIT);
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_grp <= ch_groups;
                        r_err <= 1'b0;
                        r_cnt <= '0;
                    end
                end
                ST_CHECK: begin
                    if (r_grp > C_DEPTH) r_err <= 1'b1;
                end
                ST_LOAD: begin
                    r_bias_data  <= bus.fifo_dout;
                    r_bias_valid <= 1'b1;
                end
                ST_PRESENT: begin
                    if (bus.bias_ready) begin
                        r_bias_valid <= 1'b0;
                        r_cnt        <= r_cnt + C_ONE;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/image_bias_ctrl.md
IMAGE_BIAS_CTRL -- requirements
Module: image_bias_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 256, giving the bias word width.
REQ-002 SHALL have parameter ADDR_BITS, default 12, where bias FIFO depth = 2**ADDR_BITS = 4096.
REQ-003 SHALL have port clk, input, 1, the single clock for all logic.
REQ-004 SHALL have port rst, input, 1, reset, asynchronous and active-low.
REQ-005 SHALL have port start, input, 1, one-cycle pulse that begins a layer's bias load.
REQ-006 SHALL have port ch_groups, input, ADDR_BITS+1, the number of bias words in the layer, sampled on start.
REQ-007 SHALL have port busy, output, 1, high in every state except IDLE.
REQ-008 SHALL have port done, output, 1, one-cycle pulse at the end of a layer.
REQ-009 SHALL have port err, output, 1, sticky flag meaning ch_groups exceeded the FIFO depth; cleared by the next start.
REQ-010 SHALL have port s_valid, input, 1, upstream (DMA) bias word valid.
REQ-011 SHALL have port s_data, input, WIDTH, upstream bias word.
REQ-012 SHALL have port s_ready, output, 1, upstream ready.
REQ-013 SHALL have port fifo_din, output, WIDTH, bias FIFO write data.
REQ-014 SHALL have port fifo_wr_en, output, 1, bias FIFO write enable.
REQ-015 SHALL have port fifo_rd_en, output, 1, bias FIFO read enable.
REQ-016 SHALL have port fifo_dout, input, WIDTH, bias FIFO read data, valid 1 cycle after fifo_rd_en.
REQ-017 SHALL have port fifo_M_count, output, ADDR_BITS+1, the read threshold driven to the FIFO.
REQ-018 SHALL have port fifo_M_Valid, input, 1, registered FIFO flag meaning data_count >= M_count.
REQ-019 SHALL have port fifo_S_count, output, ADDR_BITS+1, the write-space threshold driven to the FIFO.
REQ-020 SHALL have port fifo_S_Ready, input, 1, registered FIFO flag meaning data_count + S_count < 4096.
REQ-021 SHALL have port bias_data, output, WIDTH, bias word presented to the compute engine.
REQ-022 SHALL have port bias_valid, output, 1, bias_data valid.
REQ-023 SHALL have port bias_ready, input, 1, compute engine accepts bias_data.

Function
REQ-024 SHALL drive fifo_din = s_data, fifo_wr_en = s_valid & fifo_S_Ready, s_ready = fifo_S_Ready (combinational), and fifo_S_count = 2 to cover one cycle of flag staleness.
REQ-025 SHALL accept writes in every state, independently of the read FSM.
REQ-026 SHALL implement FSM states IDLE, CHECK, WAIT, POP, LOAD, PRESENT and DONE.
REQ-027 SHALL, in IDLE on start: latch ch_groups into grp_q, clear err, clear cnt, and go to CHECK; SHALL ignore start in every state other than IDLE.
REQ-028 SHALL, in CHECK: go to DONE if grp_q == 0; else set err and go to DONE if grp_q > 4096; else go to WAIT.
REQ-029 SHALL drive fifo_M_count = grp_q in WAIT (0 otherwise), so the whole layer's bias is resident before the first pop.
REQ-030 SHALL, in WAIT: stay one extra cycle after entry (the flag is registered), then go to POP when fifo_M_Valid == 1.
REQ-031 SHALL, in POP: assert fifo_rd_en for exactly one cycle, then go to LOAD.
REQ-032 SHALL, in LOAD: register fifo_dout into bias_data, set bias_valid, then go to PRESENT.
REQ-033 SHALL, in PRESENT: hold bias_valid and bias_data stable until bias_ready.
REQ-034 SHALL, on bias_valid & bias_ready: clear bias_valid and increment cnt; go to DONE if cnt == grp_q-1, else go to POP.
REQ-035 SHALL give a throughput of one bias word per 3 cycles when bias_ready is held at 1.
REQ-036 SHALL, in DONE: pulse done for 1 cycle, then go to IDLE.
REQ-037 SHALL size cnt at ADDR_BITS+1 bits, with no wrap within a layer.
REQ-038 SHALL assert fifo_rd_en only in POP, so the FIFO never underflows.

Reset
REQ-039 SHALL, on rst low (asynchronous): state = IDLE; busy, done, err, bias_valid and fifo_rd_en = 0; bias_data = 0; cnt = 0; grp_q = 0.
REQ-040 SHALL, on reset mid-layer: abandon the layer with no done pulse, leave FIFO contents untouched, and require a new start to begin again.
REQ-041 SHALL release reset synchronously to clk, which is the integrator's responsibility.

Structure
REQ-042 SHALL take the FSM state encoding and the FIFO depth constant (4096) from a shared package, image_bias_pkg.
REQ-043 SHALL instantiate no sub-module; the FIFO is external, and the natural sibling wrapper is image_bias_fifo.

Verification
REQ-044 SHALL pass this scenario: preload 8 words 0..7, start with ch_groups = 8, bias_ready = 1 -> bias_data 0..7 in order, one word per 3 cycles, then 1 done pulse, err = 0.
REQ-045 SHALL pass this scenario: start with ch_groups = 4 and an empty FIFO, then write 4 words 10 cycles later -> no fifo_rd_en until M_Valid, then 4 words delivered.
REQ-046 SHALL pass this scenario: ch_groups = 0 -> done pulse 2 cycles after start and no fifo_rd_en; ch_groups = 4097 -> err = 1 and done.
REQ-047 SHALL pass this scenario: bias_ready low for 5 cycles in PRESENT -> bias_data and bias_valid stable, with no extra fifo_rd_en.
REQ-048 SHALL pass this scenario: FIFO at 4094 entries with s_valid = 1 -> s_ready drops and occupancy never exceeds 4096.
REQ-049 SHALL pass this scenario: rst asserted in PRESENT -> all outputs reach reset values immediately, with no done pulse.
